// File: rtl/ie_input_conditioner_if.sv
// Switch/button bus between the board pins and the IE01/IE02 decoding logic.
// The master drives the raw pin levels; the slave returns the conditioned signals.
interface ie_input_conditioner_if;
  logic [7:0] CH_RAW;
  logic [3:0] B_RAW;
  logic [7:0] CH_OUT;
  logic [3:0] B_LEVEL;
  logic [3:0] B_PRESS;
  logic [1:0] PERF_CHG;

  modport master (
    output CH_RAW, B_RAW,
    input  CH_OUT, B_LEVEL, B_PRESS, PERF_CHG
  );

  modport slave (
    input  CH_RAW, B_RAW,
    output CH_OUT, B_LEVEL, B_PRESS, PERF_CHG
  );
endinterface

// File: rtl/ie_input_conditioner.sv
// Synchronises and debounces CH7..CH0 and B3..B0 and generates press and profile-change pulses.
// Optional macro PRESS_REPEAT_EN adds per-button auto-repeat of B_PRESS while a button is held.
module ie_input_conditioner #(
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  ie_input_conditioner_if.slave bus
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [7:0]  ch_sync1_q, ch_sync1_d, ch_sync2_q, ch_sync2_d;
  logic [3:0]  b_sync1_q, b_sync1_d, b_sync2_q, b_sync2_d;
  logic [11:0] stable_q, stable_d;
  logic [CW-1:0] cnt_q [12];
  logic [CW-1:0] cnt_d [12];
  logic [3:0]  press_q, press_d;
  logic [1:0]  perf_q, perf_d;

  logic [11:0] sync_in;
  logic [11:0] accept;

  // Channels 11..8 carry the buttons, already inverted to active-high.
  assign sync_in = {~b_sync2_q, ch_sync2_q};

`ifdef PRESS_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q [4];
  logic [RW-1:0] rep_d [4];
`endif

  always_comb begin
    ch_sync1_d = bus.CH_RAW;
    ch_sync2_d = ch_sync1_q;
    b_sync1_d  = bus.B_RAW;
    b_sync2_d  = b_sync1_q;
    stable_d   = stable_q;
    accept     = '0;
    for (int i = 0; i < 12; i++) begin
      cnt_d[i] = '0;
      if (sync_in[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync_in[i];
          accept[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    press_d = accept[11:8] & sync_in[11:8];
    perf_d  = {|accept[7:5], |accept[3:1]};
`ifdef PRESS_REPEAT_EN
    // The repeat period is measured from the cycle the previous pulse is visible.
    for (int i = 0; i < 4; i++) begin
      rep_d[i] = '0;
      if (!press_d[i] && stable_d[8+i]) begin
        if (rep_q[i] == REP_LAST) begin
          press_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + RW'(1);
        end
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_sync1_q <= '0;
      ch_sync2_q <= '0;
      b_sync1_q  <= '1;
      b_sync2_q  <= '1;
      stable_q   <= '0;
      press_q    <= '0;
      perf_q     <= '0;
      for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
`ifdef PRESS_REPEAT_EN
      for (int i = 0; i < 4; i++) rep_q[i] <= '0;
`endif
    end else begin
      ch_sync1_q <= ch_sync1_d;
      ch_sync2_q <= ch_sync2_d;
      b_sync1_q  <= b_sync1_d;
      b_sync2_q  <= b_sync2_d;
      stable_q   <= stable_d;
      press_q    <= press_d;
      perf_q     <= perf_d;
      for (int i = 0; i < 12; i++) cnt_q[i] <= cnt_d[i];
`ifdef PRESS_REPEAT_EN
      for (int i = 0; i < 4; i++) rep_q[i] <= rep_d[i];
`endif
    end
  end

  assign bus.CH_OUT   = stable_q[7:0];
  assign bus.B_LEVEL  = stable_q[11:8];
  assign bus.B_PRESS  = press_q;
  assign bus.PERF_CHG = perf_q;

endmodule

// File: tb/tb_ie_input_conditioner.sv
// Directed bench for ie_input_conditioner with DEB_CYCLES=4 and REPEAT_CYCLES=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ie_input_conditioner;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  ie_input_conditioner_if bus ();

  ie_input_conditioner #(
    .DEB_CYCLES    (4),
    .REPEAT_CYCLES (10)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [7:0] ch, input logic [3:0] b);
    bus.CH_RAW = ch;
    bus.B_RAW  = b;
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    RST = 1'b1;
    applyStimulus(8'h00, 4'hF);
    tick(3);
    checkOutput("rst_ch_out", 32'(bus.CH_OUT), 32'h0);
    checkOutput("rst_b_level", 32'(bus.B_LEVEL), 32'h0);
    checkOutput("rst_b_press", 32'(bus.B_PRESS), 32'h0);
    checkOutput("rst_perf_chg", 32'(bus.PERF_CHG), 32'h0);
    RST = 1'b0;
    tick(3);

    // Clean switch edge on CH7
    applyStimulus(8'h80, 4'hF);
    tick(5);
    checkOutput("clean_early", 32'(bus.CH_OUT), 32'h00);
    tick(1);
    checkOutput("clean_ch_out", 32'(bus.CH_OUT), 32'h80);
    checkOutput("clean_perf", 32'(bus.PERF_CHG), 32'h2);
    checkOutput("clean_press", 32'(bus.B_PRESS), 32'h0);
    tick(1);
    checkOutput("clean_perf_end", 32'(bus.PERF_CHG), 32'h0);
    checkOutput("clean_hold", 32'(bus.CH_OUT), 32'h80);

    // Bounce on B2 with two-cycle dwell, then held pressed
    applyStimulus(8'h80, 4'b1011);
    for (int k = 0; k < 2; k++) begin tick(1); checkOutput("bounce_lvl", 32'(bus.B_LEVEL), 32'h0); end
    applyStimulus(8'h80, 4'b1111);
    for (int k = 0; k < 2; k++) begin tick(1); checkOutput("bounce_lvl", 32'(bus.B_LEVEL), 32'h0); end
    applyStimulus(8'h80, 4'b1011);
    tick(5);
    checkOutput("bounce_early", 32'(bus.B_LEVEL), 32'h0);
    tick(1);
    checkOutput("bounce_level", 32'(bus.B_LEVEL), 32'h4);
    checkOutput("bounce_press", 32'(bus.B_PRESS), 32'h4);
    tick(1);
    checkOutput("bounce_press_end", 32'(bus.B_PRESS), 32'h0);
    applyStimulus(8'h80, 4'b1111);
    seen = 0;
    for (int k = 0; k < 8; k++) begin tick(1); if (bus.B_PRESS != 4'h0) seen++; end
    checkOutput("release_no_press", 32'(seen), 32'h0);
    checkOutput("release_level", 32'(bus.B_LEVEL), 32'h0);

    // Group coalescing on CH3..CH1, then CH0 alone
    applyStimulus(8'h00, 4'hF);
    tick(10);
    applyStimulus(8'h0E, 4'hF);
    tick(6);
    checkOutput("group_ch_out", 32'(bus.CH_OUT), 32'h0E);
    checkOutput("group_perf", 32'(bus.PERF_CHG), 32'h1);
    tick(1);
    checkOutput("group_perf_end", 32'(bus.PERF_CHG), 32'h0);
    applyStimulus(8'h0F, 4'hF);
    seen = 0;
    for (int k = 0; k < 8; k++) begin tick(1); if (bus.PERF_CHG != 2'b00) seen++; end
    checkOutput("ch0_no_perf", 32'(seen), 32'h0);
    checkOutput("ch0_ch_out", 32'(bus.CH_OUT), 32'h0F);

    // Simultaneous button and switch acceptance
    applyStimulus(8'h00, 4'hF);
    tick(10);
    applyStimulus(8'h20, 4'b0110);
    tick(6);
    checkOutput("simul_press", 32'(bus.B_PRESS), 32'h9);
    checkOutput("simul_perf", 32'(bus.PERF_CHG), 32'h2);
    checkOutput("simul_level", 32'(bus.B_LEVEL), 32'h9);
    checkOutput("simul_ch_out", 32'(bus.CH_OUT), 32'h20);

    // Reset in the middle of a pending change
    applyStimulus(8'h00, 4'hF);
    tick(10);
    applyStimulus(8'hFF, 4'hF);
    tick(3);
    RST = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      checkOutput("midrst_ch_out", 32'(bus.CH_OUT), 32'h00);
      checkOutput("midrst_perf", 32'(bus.PERF_CHG), 32'h0);
    end
    RST = 1'b0;
    tick(5);
    checkOutput("postrst_early", 32'(bus.CH_OUT), 32'h00);
    tick(1);
    checkOutput("postrst_ch_out", 32'(bus.CH_OUT), 32'hFF);
    checkOutput("postrst_perf", 32'(bus.PERF_CHG), 32'h3);

    // Long hold of B0
    applyStimulus(8'hFF, 4'b1110);
    seen = 0;
    for (int k = 0; k < 50; k++) begin tick(1); if (bus.B_PRESS[0]) seen++; end
`ifdef PRESS_REPEAT_EN
    checkOutput("hold_press_count", 32'(seen), 32'd5);
`else
    checkOutput("hold_press_count", 32'(seen), 32'd1);
`endif
    applyStimulus(8'hFF, 4'hF);
    tick(6);
    seen = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (bus.B_PRESS[0]) seen++; end
    checkOutput("after_release_press", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
